// File: rtl/tramelblaze_intr_ctrl.sv
// Multi-source interrupt controller for the tramelblaze core: rising-edge capture,
// enable mask, fixed lowest-index priority, single INTERRUPT/ACK handshake with EOI.
module tramelblaze_intr_ctrl #(
   parameter int unsigned NUM_SRC   = 8,
   parameter logic [15:0] BASE_ADDR = 16'h0040
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [NUM_SRC-1:0] SRC_IN,
   input  logic [15:0]        PORT_ID,
   input  logic [15:0]        OUT_PORT,
   input  logic               WRITE_STROBE,
   input  logic               READ_STROBE,
   output logic [15:0]        IN_DATA,
   output logic               INTERRUPT,
   input  logic               INTERRUPT_ACK
);

   localparam int unsigned DW  = 16;
   localparam int unsigned IDW = 4;

   localparam logic [15:0] ADDR_EN   = BASE_ADDR;
   localparam logic [15:0] ADDR_PEND = BASE_ADDR + 16'd1;
   localparam logic [15:0] ADDR_CUR  = BASE_ADDR + 16'd2;
   localparam logic [15:0] ADDR_EOI  = BASE_ADDR + 16'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] en_q, en_d;
   logic [IDW-1:0]     cur_id_q, cur_id_d;
   logic               int_q, int_d;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] ack_mask;
   logic [IDW-1:0]     win_id;
   logic               wr_en, wr_pend, wr_eoi;
   logic               unused_c;

   assign rise    = SRC_IN & ~src_q;
   assign req     = pend_q & en_q;
   assign wr_en   = WRITE_STROBE && (PORT_ID == ADDR_EN);
   assign wr_pend = WRITE_STROBE && (PORT_ID == ADDR_PEND);
   assign wr_eoi  = WRITE_STROBE && (PORT_ID == ADDR_EOI);

   // Reads are side-effect free; strobe and unused data bits are intentionally ignored.
   assign unused_c = ^{READ_STROBE, OUT_PORT};

   // Lowest-index requesting source wins.
   always_comb begin
      win_id = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (req[i]) win_id = IDW'(i);
      end
   end

   always_comb begin
      ack_mask = '0;
      for (int i = 0; i < int'(NUM_SRC); i++) begin
         ack_mask[i] = (IDW'(i) == cur_id_q);
      end
   end

   // Next-state and register update logic; a same-cycle rise always re-sets pending.
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      en_d     = en_q;
      cur_id_d = cur_id_q;
      int_d    = int_q;

      if (wr_en)   en_d   = OUT_PORT[NUM_SRC-1:0];
      if (wr_pend) pend_d = pend_d & ~OUT_PORT[NUM_SRC-1:0];

      case (state_q)
         IDLE: begin
            if (|req) begin
               cur_id_d = win_id;
               int_d    = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (INTERRUPT_ACK) begin
               pend_d  = pend_d & ~ack_mask;
               int_d   = 1'b0;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            if (wr_eoi) state_d = IDLE;
         end
         default: begin
            int_d   = 1'b0;
            state_d = IDLE;
         end
      endcase

      pend_d = pend_d | rise;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= IDLE;
         src_q    <= '0;
         pend_q   <= '0;
         en_q     <= '0;
         cur_id_q <= '0;
         int_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= SRC_IN;
         pend_q   <= pend_d;
         en_q     <= en_d;
         cur_id_q <= cur_id_d;
         int_q    <= int_d;
      end
   end

   assign INTERRUPT = int_q;

   // Port-bus read mux; unmapped and write-only addresses return zero.
   always_comb begin
      IN_DATA = '0;
      if (PORT_ID == ADDR_EN)        IN_DATA = DW'(en_q);
      else if (PORT_ID == ADDR_PEND) IN_DATA = DW'(pend_q);
      else if (PORT_ID == ADDR_CUR)  IN_DATA = {(state_q == SERVICE), 11'd0, cur_id_q};
   end

endmodule

// File: tb/tb_tramelblaze_intr_ctrl.sv
// Self-checking bench for tramelblaze_intr_ctrl: register vectors, handshake
// sequences and a randomized priority/served-set model.
module tb_tramelblaze_intr_ctrl;

   localparam int unsigned NSRC = 8;
   localparam logic [15:0] BASE   = 16'h0040;
   localparam logic [15:0] R_EN   = BASE;
   localparam logic [15:0] R_PEND = BASE + 16'd1;
   localparam logic [15:0] R_CUR  = BASE + 16'd2;
   localparam logic [15:0] R_EOI  = BASE + 16'd3;

   logic            CLK;
   logic            RESET_N;
   logic [NSRC-1:0] SRC_IN;
   logic [15:0]     PORT_ID;
   logic [15:0]     OUT_PORT;
   logic            WRITE_STROBE;
   logic            READ_STROBE;
   logic [15:0]     IN_DATA;
   logic            INTERRUPT;
   logic            INTERRUPT_ACK;

   tramelblaze_intr_ctrl #(.NUM_SRC(NSRC), .BASE_ADDR(BASE)) dut (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .SRC_IN       (SRC_IN),
      .PORT_ID      (PORT_ID),
      .OUT_PORT     (OUT_PORT),
      .WRITE_STROBE (WRITE_STROBE),
      .READ_STROBE  (READ_STROBE),
      .IN_DATA      (IN_DATA),
      .INTERRUPT    (INTERRUPT),
      .INTERRUPT_ACK(INTERRUPT_ACK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] rd_addr;
      logic [15:0] exp;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      PORT_ID      = a;
      OUT_PORT     = d;
      WRITE_STROBE = 1'b1;
      tick();
      WRITE_STROBE = 1'b0;
      PORT_ID      = 16'h0000;
      OUT_PORT     = 16'h0000;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] v);
      PORT_ID     = a;
      READ_STROBE = 1'b1;
      #2;
      v = IN_DATA;
      tick();
      READ_STROBE = 1'b0;
      PORT_ID     = 16'h0000;
   endtask

   task automatic chk_rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
      logic [15:0] v;
      rd(a, v);
      chk(nm, v, exp);
   endtask

   task automatic chk_int(input string nm, input logic exp);
      chk(nm, 16'(INTERRUPT), 16'(exp));
   endtask

   task automatic ack();
      INTERRUPT_ACK = 1'b1;
      tick();
      INTERRUPT_ACK = 1'b0;
   endtask

   task automatic pulse(input logic [NSRC-1:0] m);
      SRC_IN = m;
      tick();
      SRC_IN = '0;
   endtask

   task automatic wait_int(input string nm);
      int n = 0;
      while (!INTERRUPT && n < 20) begin
         tick();
         n++;
      end
      chk_int(nm, 1'b1);
   endtask

   function automatic int lowest(input logic [NSRC-1:0] m);
      for (int b = 0; b < int'(NSRC); b++) if (m[b]) return b;
      return -1;
   endfunction

   initial begin
      logic [15:0]     v;
      logic [NSRC-1:0] set, en, orig, served;
      int              w, hi, guard;

      RESET_N       = 1'b0;
      SRC_IN        = '0;
      PORT_ID       = 16'h0000;
      OUT_PORT      = 16'h0000;
      WRITE_STROBE  = 1'b0;
      READ_STROBE   = 1'b0;
      INTERRUPT_ACK = 1'b0;
      repeat (3) tick();

      // Reset state
      chk_int("rst_int", 1'b0);
      chk_rd("rst_en", R_EN, 16'h0000);
      chk_rd("rst_pend", R_PEND, 16'h0000);
      chk_rd("rst_cur", R_CUR, 16'h0000);
      RESET_N = 1'b1;
      tick();

      // Register access vectors
      vt[0] = '{1'b1, R_EN,     16'hFFFF, R_EN,     16'h00FF};
      vt[1] = '{1'b1, R_EN,     16'h00A5, R_EN,     16'h00A5};
      vt[2] = '{1'b1, R_CUR,    16'h1234, R_CUR,    16'h0000};
      vt[3] = '{1'b1, R_EOI,    16'hFFFF, R_CUR,    16'h0000};
      vt[4] = '{1'b1, R_PEND,   16'hFFFF, R_PEND,   16'h0000};
      vt[5] = '{1'b0, 16'h0000, 16'h0000, 16'h0044, 16'h0000};
      vt[6] = '{1'b0, 16'h0000, 16'h0000, 16'h003F, 16'h0000};
      vt[7] = '{1'b1, 16'h0045, 16'h00FF, R_EN,     16'h00A5};
      vt[8] = '{1'b1, R_EN,     16'h0000, R_EN,     16'h0000};
      for (int i = 0; i < 9; i++) begin
         if (vt[i].wr) wr(vt[i].addr, vt[i].data);
         rd(vt[i].rd_addr, v);
         chk($sformatf("vec%0d", i), v, vt[i].exp);
      end
      chk_int("vec_int", 1'b0);

      // 1: single source latency and handshake
      wr(R_EN, 16'h00FF);
      pulse(8'h08);
      chk_int("t1_int_n", 1'b0);
      tick();
      chk_int("t1_int_n1", 1'b1);
      chk_rd("t1_cur_req", R_CUR, 16'h0003);
      ack();
      chk_int("t1_int_ack", 1'b0);
      chk_rd("t1_cur_svc", R_CUR, 16'h8003);
      chk_rd("t1_pend", R_PEND, 16'h0000);
      wr(R_EOI, 16'h0000);
      chk_rd("t1_cur_eoi", R_CUR, 16'h0003);
      chk_int("t1_int_eoi", 1'b0);

      // 2: simultaneous rises, priority and re-assert after EOI
      pulse(8'h24);
      wait_int("t2_int");
      chk_rd("t2_cur_req", R_CUR, 16'h0002);
      chk_rd("t2_pend", R_PEND, 16'h0024);
      ack();
      chk_rd("t2_pend_ack", R_PEND, 16'h0020);
      chk_rd("t2_cur_svc", R_CUR, 16'h8002);
      wr(R_EOI, 16'h5A5A);
      chk_int("t2_int_eoi", 1'b0);
      tick();
      chk_int("t2_int_reassert", 1'b1);
      ack();
      chk_rd("t2_cur_svc5", R_CUR, 16'h8005);
      wr(R_EOI, 16'h0000);

      // 3: masked pending, W1C in IDLE, late enable, W1C/EOI during REQ
      wr(R_EN, 16'h0000);
      pulse(8'h02);
      tick();
      chk_rd("t3_pend", R_PEND, 16'h0002);
      chk_int("t3_masked", 1'b0);
      wr(R_PEND, 16'h0002);
      chk_rd("t3_w1c_idle", R_PEND, 16'h0000);
      pulse(8'h02);
      chk_rd("t3_pend2", R_PEND, 16'h0002);
      wr(R_EN, 16'h0002);
      chk_int("t3_int_w", 1'b0);
      tick();
      chk_int("t3_int_w1", 1'b1);
      wr(R_EOI, 16'h0000);
      chk_int("t3_eoi_req_ign", 1'b1);
      wr(R_PEND, 16'h0002);
      chk_rd("t3_pend_req_w1c", R_PEND, 16'h0000);
      chk_int("t3_int_hold", 1'b1);
      ack();
      chk_int("t3_int_ack", 1'b0);
      ack();
      chk_rd("t3_cur_svc", R_CUR, 16'h8001);
      wr(R_EOI, 16'h0000);

      // 4: held level is one event; rise coincident with ACK keeps pending
      wr(R_EN, 16'h00FF);
      SRC_IN = 8'h10;
      wait_int("t4_int");
      chk_rd("t4_cur", R_CUR, 16'h0004);
      ack();
      wr(R_EOI, 16'h0000);
      hi = 0;
      repeat (45) begin
         tick();
         if (INTERRUPT) hi++;
      end
      chk("t4_level_once", 16'(hi), 16'h0000);
      chk_rd("t4_pend_level", R_PEND, 16'h0000);
      SRC_IN = '0;
      tick();
      pulse(8'h10);
      wait_int("t4_int2");
      SRC_IN        = 8'h10;
      INTERRUPT_ACK = 1'b1;
      tick();
      SRC_IN        = '0;
      INTERRUPT_ACK = 1'b0;
      chk_int("t4_int_ack", 1'b0);
      chk_rd("t4_pend_keep", R_PEND, 16'h0010);
      chk_rd("t4_cur_svc", R_CUR, 16'h8004);
      wr(R_EOI, 16'h0000);
      wait_int("t4_reint");
      ack();
      wr(R_EOI, 16'h0000);
      chk_rd("t4_pend_done", R_PEND, 16'h0000);

      // 5: randomized sources and enables against a served-set model
      for (int it = 0; it < 10; it++) begin
         orig = 8'($urandom_range(1, 255));
         en   = 8'($urandom_range(1, 255));
         set  = orig;
         served = '0;
         wr(R_EN, {8'h00, en});
         pulse(orig);
         guard = 0;
         while ((set & en) != '0 && guard < 16) begin
            guard++;
            w = lowest(set & en);
            wait_int($sformatf("t5_%0d_int", it));
            chk_rd($sformatf("t5_%0d_cur_req", it), R_CUR, 16'(w));
            ack();
            chk_rd($sformatf("t5_%0d_cur_svc", it), R_CUR, 16'h8000 | 16'(w));
            set[w]    = 1'b0;
            served[w] = 1'b1;
            chk_rd($sformatf("t5_%0d_pend", it), R_PEND, {8'h00, set});
            wr(R_EOI, 16'($urandom));
         end
         tick();
         chk_int($sformatf("t5_%0d_idle", it), 1'b0);
         chk($sformatf("t5_%0d_served", it), {8'h00, served}, {8'h00, orig & en});
         chk_rd($sformatf("t5_%0d_left", it), R_PEND, {8'h00, orig & ~en});
         wr(R_PEND, 16'hFFFF);
         hi = 0;
         repeat (100) begin
            tick();
            if (INTERRUPT) hi++;
         end
         chk($sformatf("t5_%0d_gap", it), 16'(hi), 16'h0000);
      end

      // 6: asynchronous reset during SERVICE
      wr(R_EN, 16'h00FF);
      pulse(8'h01);
      wait_int("t6_int");
      ack();
      chk_rd("t6_cur_svc", R_CUR, 16'h8000);
      pulse(8'h40);
      #2;
      RESET_N = 1'b0;
      #1;
      chk_int("t6_int_rst", 1'b0);
      PORT_ID = R_EN;
      #1;
      chk("t6_en_rst", IN_DATA, 16'h0000);
      PORT_ID = R_PEND;
      #1;
      chk("t6_pend_rst", IN_DATA, 16'h0000);
      PORT_ID = R_CUR;
      #1;
      chk("t6_cur_rst", IN_DATA, 16'h0000);
      PORT_ID = 16'h0000;
      tick();
      RESET_N = 1'b1;
      repeat (3) tick();
      chk_int("t6_int_after", 1'b0);
      chk_rd("t6_en_after", R_EN, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
